// File: rtl/ir_freq_detector_if.sv
// Result bundle from the IR frequency detector to the beacon tracker.
// master drives the classification, slave observes it.
interface ir_freq_detector_if #(
    parameter int CNT_W = 20
);
    logic [1:0]       freq_code;
    logic             valid;
    logic [CNT_W-1:0] period;
    logic             sample_stb;

    modport master (
        output freq_code,
        output valid,
        output period,
        output sample_stb
    );

    modport slave (
        input freq_code,
        input valid,
        input period,
        input sample_stb
    );
endinterface

// File: rtl/ir_freq_detector.sv
// IR period classifier: measures the demodulated IR period and reports a
// 1/2/3 kHz code after a run of consistent periods, dropping it on loss.
module ir_freq_detector #(
    parameter int CNT_W    = 20,
    parameter int PER_1K   = 100000,
    parameter int PER_2K   = 50000,
    parameter int PER_3K   = 33333,
    parameter int TOL      = 2000,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 250000
) (
    input  logic               CLK100MHZ,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               ir_in,
    ir_freq_detector_if.master det
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Run counters hold one past LOCK_CNT so LOCK_CNT=1 cannot wrap.
    localparam int CW = $clog2(LOCK_CNT + 2);
    localparam logic [CW-1:0]    LOCK_N  = CW'(LOCK_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    localparam int LO1 = PER_1K - TOL;
    localparam int HI1 = PER_1K + TOL;
    localparam int LO2 = PER_2K - TOL;
    localparam int HI2 = PER_2K + TOL;
    localparam int LO3 = PER_3K - TOL;
    localparam int HI3 = PER_3K + TOL;

    logic             s1_q;
    logic             s2_q;
    logic             s3_q;
    logic             rise;
    logic             tmo;
    logic [CNT_W-1:0] per_cnt_q;
    logic [CNT_W-1:0] meas;
    logic [1:0]       cls;
    state_t           state_q;
    logic [1:0]       cand_q;
    logic [CW-1:0]    match_q;
    logic [CW-1:0]    match_d;
    logic [CW-1:0]    miss_q;
    logic [CW-1:0]    miss_d;
    logic [1:0]       code_q;
    logic             valid_q;
    logic [CNT_W-1:0] period_q;
    logic             stb_q;

    assign rise = s2_q & ~s3_q;
    assign meas = per_cnt_q + CNT_W'(1);
    assign tmo  = (per_cnt_q == TO_LAST);

    // Priority order: the lowest matching code wins.
    always_comb begin
        int p;
        p   = int'(meas);
        cls = 2'b00;
        if (p >= LO1 && p <= HI1) begin
            cls = 2'b01;
        end else if (p >= LO2 && p <= HI2) begin
            cls = 2'b10;
        end else if (p >= LO3 && p <= HI3) begin
            cls = 2'b11;
        end
    end

    always_comb begin
        match_d = CW'(1);
        if (cls == 2'b00) begin
            match_d = '0;
        end else if (cls == cand_q) begin
            match_d = match_q + CW'(1);
        end
        miss_d = '0;
        if (cls != code_q) begin
            miss_d = miss_q + CW'(1);
        end
    end

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            per_cnt_q <= '0;
            state_q   <= IDLE;
            cand_q    <= 2'b00;
            match_q   <= '0;
            miss_q    <= '0;
            code_q    <= 2'b00;
            valid_q   <= 1'b0;
            period_q  <= '0;
            stb_q     <= 1'b0;
        end else begin
            s1_q  <= ir_in;
            s2_q  <= s1_q;
            s3_q  <= s2_q;
            stb_q <= 1'b0;
            if (!enable) begin
                per_cnt_q <= '0;
                state_q   <= IDLE;
                cand_q    <= 2'b00;
                match_q   <= '0;
                miss_q    <= '0;
                code_q    <= 2'b00;
                valid_q   <= 1'b0;
                period_q  <= '0;
            end else begin
                if (rise) begin
                    per_cnt_q <= '0;
                end else if (per_cnt_q != CNT_MAX) begin
                    per_cnt_q <= per_cnt_q + CNT_W'(1);
                end
                unique case (state_q)
                    IDLE: begin
                        if (rise) begin
                            state_q <= ACQUIRE;
                            cand_q  <= 2'b00;
                            match_q <= '0;
                        end
                    end
                    ACQUIRE: begin
                        if (rise) begin
                            period_q <= meas;
                            stb_q    <= 1'b1;
                            cand_q   <= cls;
                            if (match_d >= LOCK_N) begin
                                state_q <= LOCKED;
                                code_q  <= cls;
                                valid_q <= 1'b1;
                                match_q <= '0;
                                miss_q  <= '0;
                            end else begin
                                match_q <= match_d;
                            end
                        end else if (tmo) begin
                            state_q   <= IDLE;
                            per_cnt_q <= '0;
                            cand_q    <= 2'b00;
                            match_q   <= '0;
                            miss_q    <= '0;
                        end
                    end
                    LOCKED: begin
                        if (rise) begin
                            period_q <= meas;
                            stb_q    <= 1'b1;
                            if (miss_d >= LOCK_N) begin
                                state_q <= ACQUIRE;
                                code_q  <= 2'b00;
                                valid_q <= 1'b0;
                                cand_q  <= cls;
                                match_q <= (cls != 2'b00) ? CW'(1) : '0;
                                miss_q  <= '0;
                            end else begin
                                miss_q <= miss_d;
                            end
                        end else if (tmo) begin
                            state_q   <= IDLE;
                            per_cnt_q <= '0;
                            code_q    <= 2'b00;
                            valid_q   <= 1'b0;
                            cand_q    <= 2'b00;
                            match_q   <= '0;
                            miss_q    <= '0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign det.freq_code  = code_q;
    assign det.valid      = valid_q;
    assign det.period     = period_q;
    assign det.sample_stb = stb_q;

endmodule

// File: tb/tb_ir_freq_detector.sv
// Scoreboard bench for ir_freq_detector with scaled-down periods so that
// whole lock/unlock/timeout sequences fit in a short run.
module tb_ir_freq_detector;

    localparam int CNT_W = 10;
    localparam int P1    = 200;
    localparam int P2    = 100;
    localparam int P3    = 66;
    localparam int TOL   = 4;
    localparam int LK    = 4;
    localparam int TMO   = 500;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic enable = 1'b0;
    logic ir_in  = 1'b0;

    ir_freq_detector_if #(.CNT_W(CNT_W)) det ();

    ir_freq_detector #(
        .CNT_W    (CNT_W),
        .PER_1K   (P1),
        .PER_2K   (P2),
        .PER_3K   (P3),
        .TOL      (TOL),
        .LOCK_CNT (LK),
        .TIMEOUT  (TMO)
    ) dut (
        .CLK100MHZ (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .ir_in     (ir_in),
        .det       (det)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit drop;
        int per;
        int code;
        bit vld;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    bit   m_armed  = 0;
    bit   m_locked = 0;
    int   m_code   = 0;
    int   m_last   = 0;
    int   hist[$];

    function automatic void chk(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic int classify(int p);
        if (p >= P1 - TOL && p <= P1 + TOL) return 1;
        if (p >= P2 - TOL && p <= P2 + TOL) return 2;
        if (p >= P3 - TOL && p <= P3 + TOL) return 3;
        return 0;
    endfunction

    // eq=1: last LK codes all equal v; eq=0: last LK codes all differ from v
    function automatic bit tail(bit eq, int v);
        if (hist.size() < LK) return 0;
        for (int i = hist.size() - LK; i < hist.size(); i++)
            if ((hist[i] == v) != eq) return 0;
        return 1;
    endfunction

    function automatic void model_rise(int t);
        int p;
        int c;
        exp_t e;
        if (!m_armed) begin
            m_armed  = 1;
            m_locked = 0;
            m_code   = 0;
            hist.delete();
            m_last = t;
            return;
        end
        p      = t - m_last;
        m_last = t;
        c      = classify(p);
        hist.push_back(c);
        if (!m_locked) begin
            if (c != 0 && tail(1'b1, c)) begin
                m_locked = 1;
                m_code   = c;
                hist.delete();
            end
        end else if (tail(1'b0, m_code)) begin
            m_locked = 0;
            m_code   = 0;
            hist.delete();
            hist.push_back(c);
        end
        e = '{1'b0, p, m_code, m_locked};
        sb.push_back(e);
    endfunction

    function automatic void model_timeout();
        exp_t e;
        if (m_locked) begin
            e = '{1'b1, 0, 0, 1'b0};
            sb.push_back(e);
        end
        m_armed  = 0;
        m_locked = 0;
        m_code   = 0;
        hist.delete();
    endfunction

    function automatic void model_clear();
        m_armed  = 0;
        m_locked = 0;
        m_code   = 0;
        hist.delete();
        sb.delete();
    endfunction

    bit         quiet    = 1;
    int         last_stb = 0;
    logic       pv       = 1'b0;
    logic [1:0] pc       = 2'b00;

    always @(negedge clk) begin
        exp_t e;
        if (!quiet) begin
            if (det.sample_stb) begin
                last_stb = cyc;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL stb_unexpected: period %0d at cycle %0d", det.period, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("stb_kind", int'(e.drop), 0);
                    chk("period", int'(det.period), e.per);
                    chk("code_at_stb", int'(det.freq_code), e.code);
                    chk("valid_at_stb", int'(det.valid), int'(e.vld));
                end
            end else if (det.valid !== pv || det.freq_code !== pc) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL out_change_unexpected: valid %0b code %0d at cycle %0d",
                             det.valid, det.freq_code, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("drop_kind", int'(e.drop), 1);
                    chk("drop_valid", int'(det.valid), 0);
                    chk("drop_code", int'(det.freq_code), 0);
                    chk("drop_delay", cyc - last_stb, TMO);
                end
            end
        end
        pv = det.valid;
        pc = det.freq_code;
    end

    task automatic advance(int n);
        if (m_armed && (cyc + n - m_last) > TMO) model_timeout();
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rise_now();
        ir_in = 1'b1;
        model_rise(cyc);
    endtask

    task automatic wave(int per);
        int hi;
        hi = per / 2;
        rise_now();
        advance(hi);
        ir_in = 1'b0;
        advance(per - hi);
    endtask

    task automatic glitch_wave(int per);
        int hi;
        int lo;
        hi = per / 2;
        lo = per - hi;
        rise_now();
        advance(hi);
        ir_in = 1'b0;
        advance(lo / 2);
        rise_now();
        advance(1);
        ir_in = 1'b0;
        advance(lo - lo / 2 - 1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic go_idle();
        advance(TMO + 20);
        drain();
    endtask

    task automatic chk_cleared(string nm);
        chk({nm, "_valid"}, int'(det.valid), 0);
        chk({nm, "_code"}, int'(det.freq_code), 0);
        chk({nm, "_period"}, int'(det.period), 0);
        chk({nm, "_stb"}, int'(det.sample_stb), 0);
    endtask

    task automatic relock_check(string nm);
        repeat (4) wave(P1 + 1);
        drain();
        chk({nm, "_4rises_valid"}, int'(det.valid), 0);
        wave(P1 + 1);
        drain();
        chk({nm, "_5rises_valid"}, int'(det.valid), 1);
        chk({nm, "_5rises_code"}, int'(det.freq_code), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int sel;
        int off;
        int n;
        int per;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_cleared("reset");
        rst_n  = 1'b1;
        enable = 1'b1;
        @(posedge clk);
        #1;
        quiet = 0;

        // nominal 1 kHz: lock on the 5th rise
        repeat (8) wave(P1 + 1);
        drain();
        chk("t1_code", int'(det.freq_code), 1);
        chk("t1_valid", int'(det.valid), 1);

        // signal loss while locked
        go_idle();
        chk("t3_code", int'(det.freq_code), 0);
        chk("t3_valid", int'(det.valid), 0);

        // 3 kHz lock, then switch to 2 kHz
        repeat (6) wave(P3 + 1);
        drain();
        chk("t2_code3", int'(det.freq_code), 3);
        repeat (10) wave(P2 + 1);
        drain();
        chk("t2_code2", int'(det.freq_code), 2);

        // alternating in-band / out-of-band never locks
        go_idle();
        repeat (10) begin
            wave(P1 + 1);
            wave(150);
        end
        drain();
        chk("t4_alt_valid", int'(det.valid), 0);

        // three misses while locked keep the lock
        repeat (5) wave(P1 + 1);
        repeat (3) wave(150);
        repeat (2) wave(P1 + 1);
        drain();
        chk("t4_hold_valid", int'(det.valid), 1);
        chk("t4_hold_code", int'(det.freq_code), 1);

        // window edges
        go_idle();
        repeat (5) wave(P1 - TOL);
        drain();
        chk("edge_lo_code", int'(det.freq_code), 1);
        go_idle();
        repeat (5) wave(P1 + TOL);
        drain();
        chk("edge_hi_code", int'(det.freq_code), 1);
        go_idle();
        repeat (6) wave(P1 - TOL - 1);
        drain();
        chk("edge_out_valid", int'(det.valid), 0);

        // asynchronous reset mid-lock
        repeat (5) wave(P1 + 1);
        drain();
        chk("pre_rst_valid", int'(det.valid), 1);
        quiet = 1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk_cleared("arst");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        quiet = 0;
        relock_check("arst");

        // enable low for 10 clocks
        quiet  = 1;
        enable = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk_cleared("en");
        enable = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        quiet = 0;
        relock_check("en");

        // single-clock glitch while locked
        glitch_wave(P1 + 1);
        repeat (2) wave(P1 + 1);
        drain();
        chk("glitch_valid", int'(det.valid), 1);
        chk("glitch_code", int'(det.freq_code), 1);

        // randomized segments
        for (int s = 0; s < 20; s++) begin
            sel = int'($urandom_range(0, 9));
            off = int'($urandom_range(0, 2 * TOL + 4)) - (TOL + 2);
            n   = int'($urandom_range(1, 6));
            if (sel <= 2)      per = P1 + off;
            else if (sel <= 5) per = P2 + off;
            else if (sel <= 7) per = P3 + off;
            else               per = int'($urandom_range(40, 300));
            if (sel == 9) advance(TMO + int'($urandom_range(1, 30)));
            repeat (n) wave(per);
        end
        drain();
        go_idle();
        chk("final_valid", int'(det.valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
